fetch_buffer: RTL and testbench

FETCH_BUFFER -- requirements
Module: fetch_buffer

---
 rtl/fetch_buffer.sv | 152 +++++++++++++++
 tb/tb_fetch_buffer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: issues in-order memory requests with credit-based flow
// control and queues returned words (or a misaligned-fetch marker) for decode.
module fetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic [31:0] redirect_pc_i,
    output logic        inst_req_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_addr_ok_i,
    input  logic        inst_data_ok_i,
    input  logic [31:0] inst_rdata_i,
    input  logic        id_stall_i,
    output logic        id_valid_o,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc_o,
    output logic        id_adel_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [1:0]  outstanding_q, outstanding_d;
    logic [1:0]  discard_q, discard_d;
    logic        halted_q, halted_d;
    logic        pend_wr_q, pend_wr_d;
    logic        pend_rd_q, pend_rd_d;

    logic [31:0] pend_pc_q [2];
    logic [31:0] q_pc_mem    [DEPTH];
    logic [31:0] q_instr_mem [DEPTH];
    logic        q_adel_mem  [DEPTH];

    logic [CW:0] used_w;
    logic        accept_w;
    logic        resp_w;
    logic        resp_keep_w;
    logic        adel_enq_w;
    logic        enq_w;
    logic        deq_w;
    logic [31:0] enq_pc_w;
    logic [31:0] enq_instr_w;

    // Discarded-but-outstanding requests still hold credit, so overflow is impossible.
    assign used_w      = {1'b0, count_q} + (CW+1)'(outstanding_q);
    assign inst_req_o  = ~rst & ~flush_i & (fetch_pc_q[1:0] == 2'b00) & ~halted_q
                       & (outstanding_q != 2'd2) & (used_w < (CW+1)'(DEPTH));
    assign inst_addr_o = fetch_pc_q;

    assign accept_w    = inst_req_o & inst_addr_ok_i;
    assign resp_w      = inst_data_ok_i & ~rst;
    assign resp_keep_w = resp_w & ~flush_i & (discard_q == 2'd0);
    assign adel_enq_w  = ~rst & ~flush_i & ~halted_q & (fetch_pc_q[1:0] != 2'b00)
                       & (outstanding_q == 2'd0) & (count_q < CW'(DEPTH));
    assign enq_w       = resp_keep_w | adel_enq_w;
    assign deq_w       = id_valid_o & ~id_stall_i & ~flush_i;
    assign enq_pc_w    = resp_keep_w ? pend_pc_q[pend_rd_q] : fetch_pc_q;
    assign enq_instr_w = resp_keep_w ? inst_rdata_i : 32'h0;

    assign id_valid_o = ~rst & (count_q != '0);
    assign id_pc_o    = id_valid_o ? q_pc_mem[head_q]    : 32'h0;
    assign id_instr_o = id_valid_o ? q_instr_mem[head_q] : 32'h0;
    assign id_adel_o  = id_valid_o & q_adel_mem[head_q];

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        count_d       = count_q;
        head_d        = head_q;
        tail_d        = tail_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        halted_d      = halted_q;
        pend_wr_d     = pend_wr_q;
        pend_rd_d     = pend_rd_q;

        if (accept_w) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            pend_wr_d  = ~pend_wr_q;
        end
        if (resp_w) begin
            pend_rd_d = ~pend_rd_q;
        end
        case ({accept_w, resp_w})
            2'b10:   outstanding_d = outstanding_q + 2'd1;
            2'b01:   outstanding_d = outstanding_q - 2'd1;
            default: outstanding_d = outstanding_q;
        endcase
        if (resp_w && !flush_i && discard_q != 2'd0) begin
            discard_d = discard_q - 2'd1;
        end

        case ({enq_w, deq_w})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (enq_w) tail_d = tail_q + AW'(1);
        if (deq_w) head_d = head_q + AW'(1);
        if (adel_enq_w) halted_d = 1'b1;

        // Redirect wins; responses already in flight are counted for dropping.
        if (flush_i) begin
            fetch_pc_d = redirect_pc_i;
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
            halted_d   = 1'b0;
            discard_d  = outstanding_q - {1'b0, inst_data_ok_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            count_q       <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            outstanding_q <= 2'd0;
            discard_q     <= 2'd0;
            halted_q      <= 1'b0;
            pend_wr_q     <= 1'b0;
            pend_rd_q     <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            count_q       <= count_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            halted_q      <= halted_d;
            pend_wr_q     <= pend_wr_d;
            pend_rd_q     <= pend_rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept_w) begin
            pend_pc_q[pend_wr_q] <= fetch_pc_q;
        end
        if (enq_w) begin
            q_pc_mem[tail_q]    <= enq_pc_w;
            q_instr_mem[tail_q] <= enq_instr_w;
            q_adel_mem[tail_q]  <= adel_enq_w & ~resp_keep_w;
        end
    end
endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: inputs driven at negedge, outputs checked 1ns later.
module tb_fetch_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic [31:0] redirect_pc_i;
    logic        inst_req_o;
    logic [31:0] inst_addr_o;
    logic        inst_addr_ok_i;
    logic        inst_data_ok_i;
    logic [31:0] inst_rdata_i;
    logic        id_stall_i;
    logic        id_valid_o;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_o;
    logic        id_adel_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_buffer dut (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (flush_i),
        .redirect_pc_i  (redirect_pc_i),
        .inst_req_o     (inst_req_o),
        .inst_addr_o    (inst_addr_o),
        .inst_addr_ok_i (inst_addr_ok_i),
        .inst_data_ok_i (inst_data_ok_i),
        .inst_rdata_i   (inst_rdata_i),
        .id_stall_i     (id_stall_i),
        .id_valid_o     (id_valid_o),
        .id_instr_o     (id_instr_o),
        .id_pc_o        (id_pc_o),
        .id_adel_o      (id_adel_o)
    );

    task automatic drive(input logic fl, input logic [31:0] rpc, input logic aok,
                         input logic dok, input logic [31:0] rd, input logic st);
        flush_i        = fl;
        redirect_pc_i  = rpc;
        inst_addr_ok_i = aok;
        inst_data_ok_i = dok;
        inst_rdata_i   = rd;
        id_stall_i     = st;
        #1;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 32'h8000_0000, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
            @(negedge clk);
            #1;
            total++; if (inst_req_o !== 1'b0) begin bad++; $display("FAIL reset_req c=%0d got=%b exp=0", c, inst_req_o); end
            total++; if (id_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid c=%0d got=%b exp=0", c, id_valid_o); end
            total++; if (id_adel_o !== 1'b0) begin bad++; $display("FAIL reset_adel c=%0d got=%b exp=0", c, id_adel_o); end
            total++; if (id_instr_o !== 32'h0) begin bad++; $display("FAIL reset_instr c=%0d got=%h exp=0", c, id_instr_o); end
            total++; if (id_pc_o !== 32'h0) begin bad++; $display("FAIL reset_pc c=%0d got=%h exp=0", c, id_pc_o); end
        end
        $display("test_reset: total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_stream();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 32'h0, 1'b1, (k >= 1), 32'h1000_0000 + 32'(k) - 32'd1, 1'b0);
            total++; if (inst_req_o !== 1'b1) begin bad++; $display("FAIL stream_req k=%0d got=%b exp=1", k, inst_req_o); end
            total++; if (inst_addr_o !== 32'hBFC0_0000 + 32'(4*k)) begin bad++; $display("FAIL stream_addr k=%0d got=%h exp=%h", k, inst_addr_o, 32'hBFC0_0000 + 32'(4*k)); end
            if (k >= 2) begin
                total++; if (id_valid_o !== 1'b1) begin bad++; $display("FAIL stream_valid k=%0d got=%b exp=1", k, id_valid_o); end
                total++; if (id_pc_o !== 32'hBFC0_0000 + 32'(4*(k-2))) begin bad++; $display("FAIL stream_pc k=%0d got=%h exp=%h", k, id_pc_o, 32'hBFC0_0000 + 32'(4*(k-2))); end
                total++; if (id_instr_o !== 32'h1000_0000 + 32'(k-2)) begin bad++; $display("FAIL stream_instr k=%0d got=%h exp=%h", k, id_instr_o, 32'h1000_0000 + 32'(k-2)); end
            end else begin
                total++; if (id_valid_o !== 1'b0) begin bad++; $display("FAIL stream_empty k=%0d got=%b exp=0", k, id_valid_o); end
            end
            next_cycle();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h1000_0007, 1'b0);
        total++; if (id_pc_o !== 32'hBFC0_0018) begin bad++; $display("FAIL stream_tail6 got=%h exp=bfc00018", id_pc_o); end
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        total++; if (id_pc_o !== 32'hBFC0_001C) begin bad++; $display("FAIL stream_tail7_pc got=%h exp=bfc0001c", id_pc_o); end
        total++; if (id_instr_o !== 32'h1000_0007) begin bad++; $display("FAIL stream_tail7_instr got=%h exp=10000007", id_instr_o); end
        next_cycle();
        #1;
        total++; if (id_valid_o !== 1'b0) begin bad++; $display("FAIL stream_drained got=%b exp=0", id_valid_o); end
        $display("test_stream: total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_stall_fill();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 32'h0, 1'b1, (k >= 1 && k <= 4), 32'h2000_0000 + 32'(k) - 32'd1, 1'b1);
            total++; if (inst_req_o !== (k <= 3)) begin bad++; $display("FAIL fill_req k=%0d got=%b exp=%b", k, inst_req_o, (k <= 3)); end
            total++; if (inst_addr_o !== 32'hBFC0_0000 + 32'(4*((k <= 3) ? k : 4))) begin bad++; $display("FAIL fill_addr k=%0d got=%h", k, inst_addr_o); end
            total++; if (id_valid_o !== (k >= 2)) begin bad++; $display("FAIL fill_valid k=%0d got=%b exp=%b", k, id_valid_o, (k >= 2)); end
            if (k >= 2) begin
                total++; if (id_pc_o !== 32'hBFC0_0000) begin bad++; $display("FAIL fill_head k=%0d got=%h exp=bfc00000", k, id_pc_o); end
            end
            next_cycle();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
            total++; if (id_valid_o !== 1'b1) begin bad++; $display("FAIL drain_valid i=%0d got=%b exp=1", i, id_valid_o); end
            total++; if (id_pc_o !== 32'hBFC0_0000 + 32'(4*i)) begin bad++; $display("FAIL drain_pc i=%0d got=%h exp=%h", i, id_pc_o, 32'hBFC0_0000 + 32'(4*i)); end
            total++; if (id_instr_o !== 32'h2000_0000 + 32'(i)) begin bad++; $display("FAIL drain_instr i=%0d got=%h exp=%h", i, id_instr_o, 32'h2000_0000 + 32'(i)); end
            next_cycle();
        end
        #1;
        total++; if (id_valid_o !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b exp=0", id_valid_o); end
        $display("test_stall_fill: total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_flush_outstanding();
        do_reset();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        next_cycle();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        total++; if (inst_addr_o !== 32'hBFC0_0004) begin bad++; $display("FAIL fo_addr1 got=%h exp=bfc00004", inst_addr_o); end
        next_cycle();
        drive(1'b1, 32'h8000_1000, 1'b0, 1'b0, 32'h0, 1'b0);
        total++; if (inst_req_o !== 1'b0) begin bad++; $display("FAIL fo_req_flush got=%b exp=0", inst_req_o); end
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_0000, 1'b0);
        total++; if (inst_req_o !== 1'b0) begin bad++; $display("FAIL fo_req_out2 got=%b exp=0", inst_req_o); end
        total++; if (inst_addr_o !== 32'h8000_1000) begin bad++; $display("FAIL fo_redirect got=%h exp=80001000", inst_addr_o); end
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_0004, 1'b0);
        total++; if (id_valid_o !== 1'b0) begin bad++; $display("FAIL fo_drop1 got=%b exp=0", id_valid_o); end
        total++; if (inst_req_o !== 1'b1) begin bad++; $display("FAIL fo_req_out1 got=%b exp=1", inst_req_o); end
        next_cycle();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        total++; if (id_valid_o !== 1'b0) begin bad++; $display("FAIL fo_drop2 got=%b exp=0", id_valid_o); end
        total++; if (inst_addr_o !== 32'h8000_1000) begin bad++; $display("FAIL fo_addr_new got=%h exp=80001000", inst_addr_o); end
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h1234_5678, 1'b0);
        total++; if (inst_addr_o !== 32'h8000_1004) begin bad++; $display("FAIL fo_advance got=%h exp=80001004", inst_addr_o); end
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        total++; if (id_pc_o !== 32'h8000_1000) begin bad++; $display("FAIL fo_pc got=%h exp=80001000", id_pc_o); end
        total++; if (id_instr_o !== 32'h1234_5678) begin bad++; $display("FAIL fo_instr got=%h exp=12345678", id_instr_o); end
        total++; if (id_adel_o !== 1'b0) begin bad++; $display("FAIL fo_adel got=%b exp=0", id_adel_o); end
        next_cycle();
        $display("test_flush_outstanding: total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_flush_same_cycle();
        do_reset();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        next_cycle();
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h3000_0000, 1'b0);
        next_cycle();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        total++; if (inst_addr_o !== 32'hBFC0_0008) begin bad++; $display("FAIL fs_addr2 got=%h exp=bfc00008", inst_addr_o); end
        next_cycle();
        drive(1'b1, 32'h8000_2000, 1'b0, 1'b1, 32'h3000_0001, 1'b0);
        total++; if (id_pc_o !== 32'hBFC0_0000) begin bad++; $display("FAIL fs_head got=%h exp=bfc00000", id_pc_o); end
        total++; if (inst_req_o !== 1'b0) begin bad++; $display("FAIL fs_req_flush got=%b exp=0", inst_req_o); end
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h3000_0002, 1'b0);
        total++; if (id_valid_o !== 1'b0) begin bad++; $display("FAIL fs_empty got=%b exp=0", id_valid_o); end
        total++; if (inst_req_o !== 1'b1) begin bad++; $display("FAIL fs_req got=%b exp=1", inst_req_o); end
        total++; if (inst_addr_o !== 32'h8000_2000) begin bad++; $display("FAIL fs_addr got=%h exp=80002000", inst_addr_o); end
        next_cycle();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        total++; if (id_valid_o !== 1'b0) begin bad++; $display("FAIL fs_dropped got=%b exp=0", id_valid_o); end
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hCAFE_0001, 1'b0);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        total++; if (id_pc_o !== 32'h8000_2000) begin bad++; $display("FAIL fs_pc got=%h exp=80002000", id_pc_o); end
        total++; if (id_instr_o !== 32'hCAFE_0001) begin bad++; $display("FAIL fs_instr got=%h exp=cafe0001", id_instr_o); end
        next_cycle();
        $display("test_flush_same_cycle: total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_misaligned();
        do_reset();
        drive(1'b1, 32'h8000_0002, 1'b0, 1'b0, 32'h0, 1'b1);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        total++; if (inst_req_o !== 1'b0) begin bad++; $display("FAIL mis_req0 got=%b exp=0", inst_req_o); end
        total++; if (id_valid_o !== 1'b0) begin bad++; $display("FAIL mis_valid0 got=%b exp=0", id_valid_o); end
        next_cycle();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        total++; if (id_valid_o !== 1'b1) begin bad++; $display("FAIL mis_valid got=%b exp=1", id_valid_o); end
        total++; if (id_pc_o !== 32'h8000_0002) begin bad++; $display("FAIL mis_pc got=%h exp=80000002", id_pc_o); end
        total++; if (id_instr_o !== 32'h0) begin bad++; $display("FAIL mis_instr got=%h exp=0", id_instr_o); end
        total++; if (id_adel_o !== 1'b1) begin bad++; $display("FAIL mis_adel got=%b exp=1", id_adel_o); end
        total++; if (inst_req_o !== 1'b0) begin bad++; $display("FAIL mis_req1 got=%b exp=0", inst_req_o); end
        next_cycle();
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
            total++; if (inst_req_o !== 1'b0) begin bad++; $display("FAIL mis_halt_req c=%0d got=%b exp=0", c, inst_req_o); end
            if (c > 0) begin
                total++; if (id_valid_o !== 1'b0) begin bad++; $display("FAIL mis_once c=%0d got=%b exp=0", c, id_valid_o); end
            end
            next_cycle();
        end
        drive(1'b1, 32'h8000_3000, 1'b0, 1'b0, 32'h0, 1'b0);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        total++; if (inst_req_o !== 1'b1) begin bad++; $display("FAIL mis_resume_req got=%b exp=1", inst_req_o); end
        total++; if (inst_addr_o !== 32'h8000_3000) begin bad++; $display("FAIL mis_resume_addr got=%h exp=80003000", inst_addr_o); end
        next_cycle();
        $display("test_misaligned: total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_addr_hold();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
            total++; if (inst_req_o !== 1'b1) begin bad++; $display("FAIL hold_req k=%0d got=%b exp=1", k, inst_req_o); end
            total++; if (inst_addr_o !== 32'hBFC0_0000) begin bad++; $display("FAIL hold_addr k=%0d got=%h exp=bfc00000", k, inst_addr_o); end
            next_cycle();
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        total++; if (inst_addr_o !== 32'hBFC0_0004) begin bad++; $display("FAIL hold_advance got=%h exp=bfc00004", inst_addr_o); end
        next_cycle();
        $display("test_addr_hold: total=%0d bad=%0d", total, bad);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        test_reset();
        test_stream();
        test_stall_fill();
        test_flush_outstanding();
        test_flush_same_cycle();
        test_misaligned();
        test_addr_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
